ours_axi_outstanding_limiter: RTL and testbench
===============================================

Name: ours_axi_outstanding_limiter

Overview:
- Sits directly upstream of ours_axi_delay_line on the master side of an AXI port.
- Caps the number of in-flight write and read transactions by gating AW and AR issue against live outstanding counters.
- Counters decrement on B responses and on R beats that carry the last flag.
- W, B and R payloads pass through combinationally; the block adds only counters, gating, status and sticky error flags.

Parameters:
- AW_WIDTH, 32, packed AW info width
- W_WIDTH, 64, packed W info width
- B_WIDTH, 8, packed B info width
- AR_WIDTH, 32, packed AR info width
- R_WIDTH, 64, packed R info width
- R_LAST_POS, 0, bit index of the last flag inside r_info
- MAX_WR_OUTSTANDING, 4, maximum AW accepted without a B; legal range 1..255
- MAX_RD_OUTSTANDING, 4, maximum AR accepted without a final R; legal range 1..255

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- slave_aw_valid/info/ready  in/in/out  1/AW_WIDTH/1  upstream AW
- slave_w_valid/info/ready  in/in/out  1/W_WIDTH/1  upstream W
- slave_ar_valid/info/ready  in/in/out  1/AR_WIDTH/1  upstream AR
- slave_b_valid/info/ready  out/out/in  1/B_WIDTH/1  upstream B
- slave_r_valid/info/ready  out/out/in  1/R_WIDTH/1  upstream R
- master_aw/w/ar_*  mirror of the slave AW/W/AR ports, opposite direction  downstream request channels
- master_b/r_*  mirror of the slave B/R ports, opposite direction  downstream response channels
- wr_outstanding  out  CW_WR  current write count; CW_WR = $clog2(MAX_WR_OUTSTANDING+1)
- rd_outstanding  out  CW_RD  current read count; CW_RD = $clog2(MAX_RD_OUTSTANDING+1)
- err_underflow  out  1  sticky: B or R-last arrived while the matching count was 0
- clr_err  in  1  clears err_underflow

Behaviour:
- Reset (rst=1 at a clk edge): wr_outstanding=0, rd_outstanding=0, err_underflow=0.
- During reset, master_aw_valid, master_ar_valid, slave_aw_ready and slave_ar_ready are forced 0.
- W/B/R channels are pure pass-through, including during reset: master_w_* = slave_w_*, slave_w_ready = master_w_ready, and the same for B and R.
- wr_full = (wr_outstanding == MAX_WR_OUTSTANDING), using the registered count only.
  - master_aw_valid = slave_aw_valid & ~wr_full & ~rst.
  - slave_aw_ready = master_aw_ready & ~wr_full & ~rst.
  - master_aw_info = slave_aw_info.
- The AR channel is identical, using rd_full and rd_outstanding.
- There is no combinational path from a B/R handshake into AW/AR gating. At full, a same-cycle response does not free a slot; the slot becomes usable next cycle.
- Write counter update each cycle:
  - aw_fire = master_aw_valid & master_aw_ready
  - b_fire = master_b_valid & master_b_ready
  - aw_fire only: count +1
  - b_fire only with count>0: count -1
  - both: count unchanged
  - b_fire only with count==0: count stays 0 and err_underflow is set
- Read counter update: same rules with ar_fire and r_last_fire = master_r_valid & master_r_ready & master_r_info[R_LAST_POS]. Non-last R beats never change the count.
- The counter never exceeds MAX, by construction of the gating. An increment at MAX cannot occur.
- err_underflow priority: set beats clr_err in the same cycle. Otherwise clr_err=1 clears it next cycle.
- Latency: zero added cycles on every channel. AW/AR throttle decisions take effect the cycle after the count reaches MAX.
- Reset mid-operation returns the counters to 0. In-flight downstream responses arriving after reset are passed through and flag err_underflow. This is intended.
- valid must not depend on ready. The AXI rule is preserved because gating uses only registered state and slave valid.

Decomposition:
- Package ours_axi_limiter_pkg holds a constant function cnt_width(max) returning $clog2(max+1). It has no typedefs.
- Sub-module ours_outstanding_counter, parameterised by MAX, is instantiated twice (write and read).
  - Inputs: clk, rst, inc, dec.
  - Outputs: count, full, underflow_pulse.
- The top level holds only the gating, the pass-throughs and the sticky error register.

Test Plan:
- MAX_WR=4, master_aw_ready=1, B held off, 6 back-to-back AWs -> exactly 4 accepted; wr_outstanding=4; slave_aw_ready=0 from cycle 5; master_aw_valid=0.
- Full write state, then one B handshake -> wr_outstanding=3 next cycle; AW #5 accepted the cycle after; no AW accepted in the B cycle itself.
- wr_outstanding=2, AW fire and B fire in the same cycle -> count stays 2; err_underflow=0.
- Read burst of 8 beats with last only on beat 8, rd_outstanding=1 -> count stays 1 through beats 1-7, becomes 0 after beat 8.
- B with wr_outstanding=0 -> err_underflow=1 and count stays 0; clr_err pulse -> err_underflow=0 next cycle; clr_err and a new underflow in the same cycle -> err_underflow stays 1.
- rst asserted with wr_outstanding=3 and rd_outstanding=2 -> both 0 after one edge; AW/AR valid/ready are 0 while rst=1; W/B/R still mirror their inputs.

Source files
------------

// File: rtl/ours_axi_limiter_pkg.sv
// Shared helpers for the AXI outstanding-transaction limiter.
package ours_axi_limiter_pkg;

    function automatic int unsigned cnt_width(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/ours_outstanding_counter.sv
// Saturating in-flight counter: +1 on inc, -1 on dec, flags a dec seen at zero.
module ours_outstanding_counter
    import ours_axi_limiter_pkg::*;
#(
    parameter int unsigned MAX = 4,
    localparam int unsigned CW = cnt_width(MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          underflow_pulse
);

    assign full            = (count == CW'(MAX));
    assign underflow_pulse = dec & ~inc & (count == '0);

    // inc at MAX is excluded by the upstream gating, so no upper clamp is needed
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc & ~dec) begin
            count <= count + CW'(1);
        end else if (dec & ~inc & (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/ours_axi_outstanding_limiter.sv
// Caps in-flight AXI writes/reads by gating AW/AR on registered outstanding counts.
module ours_axi_outstanding_limiter
    import ours_axi_limiter_pkg::*;
#(
    parameter int unsigned AW_WIDTH           = 32,
    parameter int unsigned W_WIDTH            = 64,
    parameter int unsigned B_WIDTH            = 8,
    parameter int unsigned AR_WIDTH           = 32,
    parameter int unsigned R_WIDTH            = 64,
    parameter int unsigned R_LAST_POS         = 0,
    parameter int unsigned MAX_WR_OUTSTANDING = 4,
    parameter int unsigned MAX_RD_OUTSTANDING = 4,
    localparam int unsigned CW_WR = cnt_width(MAX_WR_OUTSTANDING),
    localparam int unsigned CW_RD = cnt_width(MAX_RD_OUTSTANDING)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                slave_aw_valid,
    input  logic [AW_WIDTH-1:0] slave_aw_info,
    output logic                slave_aw_ready,
    input  logic                slave_w_valid,
    input  logic [W_WIDTH-1:0]  slave_w_info,
    output logic                slave_w_ready,
    input  logic                slave_ar_valid,
    input  logic [AR_WIDTH-1:0] slave_ar_info,
    output logic                slave_ar_ready,
    output logic                slave_b_valid,
    output logic [B_WIDTH-1:0]  slave_b_info,
    input  logic                slave_b_ready,
    output logic                slave_r_valid,
    output logic [R_WIDTH-1:0]  slave_r_info,
    input  logic                slave_r_ready,

    output logic                master_aw_valid,
    output logic [AW_WIDTH-1:0] master_aw_info,
    input  logic                master_aw_ready,
    output logic                master_w_valid,
    output logic [W_WIDTH-1:0]  master_w_info,
    input  logic                master_w_ready,
    output logic                master_ar_valid,
    output logic [AR_WIDTH-1:0] master_ar_info,
    input  logic                master_ar_ready,
    input  logic                master_b_valid,
    input  logic [B_WIDTH-1:0]  master_b_info,
    output logic                master_b_ready,
    input  logic                master_r_valid,
    input  logic [R_WIDTH-1:0]  master_r_info,
    output logic                master_r_ready,

    output logic [CW_WR-1:0]    wr_outstanding,
    output logic [CW_RD-1:0]    rd_outstanding,
    output logic                err_underflow,
    input  logic                clr_err
);

    logic wr_full, rd_full;
    logic wr_uf, rd_uf;
    logic aw_fire, ar_fire, b_fire, r_last_fire;

    // gating sees only registered fullness, so valid never depends on ready
    assign master_aw_valid = slave_aw_valid & ~wr_full & ~rst;
    assign slave_aw_ready  = master_aw_ready & ~wr_full & ~rst;
    assign master_aw_info  = slave_aw_info;
    assign master_ar_valid = slave_ar_valid & ~rd_full & ~rst;
    assign slave_ar_ready  = master_ar_ready & ~rd_full & ~rst;
    assign master_ar_info  = slave_ar_info;

    assign master_w_valid = slave_w_valid;
    assign master_w_info  = slave_w_info;
    assign slave_w_ready  = master_w_ready;
    assign slave_b_valid  = master_b_valid;
    assign slave_b_info   = master_b_info;
    assign master_b_ready = slave_b_ready;
    assign slave_r_valid  = master_r_valid;
    assign slave_r_info   = master_r_info;
    assign master_r_ready = slave_r_ready;

    assign aw_fire     = master_aw_valid & master_aw_ready;
    assign ar_fire     = master_ar_valid & master_ar_ready;
    assign b_fire      = master_b_valid & master_b_ready;
    assign r_last_fire = master_r_valid & master_r_ready & master_r_info[R_LAST_POS];

    ours_outstanding_counter #(.MAX(MAX_WR_OUTSTANDING)) u_wr_cnt (
        .clk             (clk),
        .rst             (rst),
        .inc             (aw_fire),
        .dec             (b_fire),
        .count           (wr_outstanding),
        .full            (wr_full),
        .underflow_pulse (wr_uf)
    );

    ours_outstanding_counter #(.MAX(MAX_RD_OUTSTANDING)) u_rd_cnt (
        .clk             (clk),
        .rst             (rst),
        .inc             (ar_fire),
        .dec             (r_last_fire),
        .count           (rd_outstanding),
        .full            (rd_full),
        .underflow_pulse (rd_uf)
    );

    // a new underflow wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (wr_uf | rd_uf) begin
            err_underflow <= 1'b1;
        end else if (clr_err) begin
            err_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ours_axi_outstanding_limiter.sv
// Scoreboard bench for ours_axi_outstanding_limiter with directed stimulus.
module tb_ours_axi_outstanding_limiter;

    localparam int unsigned AW_WIDTH = 32;
    localparam int unsigned W_WIDTH  = 64;
    localparam int unsigned B_WIDTH  = 8;
    localparam int unsigned AR_WIDTH = 32;
    localparam int unsigned R_WIDTH  = 64;

    logic clk = 1'b0;
    logic rst;
    logic slave_aw_valid, slave_aw_ready;
    logic [AW_WIDTH-1:0] slave_aw_info;
    logic slave_w_valid, slave_w_ready;
    logic [W_WIDTH-1:0] slave_w_info;
    logic slave_ar_valid, slave_ar_ready;
    logic [AR_WIDTH-1:0] slave_ar_info;
    logic slave_b_valid, slave_b_ready;
    logic [B_WIDTH-1:0] slave_b_info;
    logic slave_r_valid, slave_r_ready;
    logic [R_WIDTH-1:0] slave_r_info;
    logic master_aw_valid, master_aw_ready;
    logic [AW_WIDTH-1:0] master_aw_info;
    logic master_w_valid, master_w_ready;
    logic [W_WIDTH-1:0] master_w_info;
    logic master_ar_valid, master_ar_ready;
    logic [AR_WIDTH-1:0] master_ar_info;
    logic master_b_valid, master_b_ready;
    logic [B_WIDTH-1:0] master_b_info;
    logic master_r_valid, master_r_ready;
    logic [R_WIDTH-1:0] master_r_info;
    logic [2:0] wr_outstanding, rd_outstanding;
    logic err_underflow, clr_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned aw_accepts = 0;

    typedef enum int unsigned {
        S_WR, S_RD, S_ERR, S_AW_RDY, S_AW_VLD, S_AR_RDY, S_AR_VLD,
        S_W_VLD, S_B_VLD, S_R_VLD, S_AW_ACC, S_W_INFO
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];

    ours_axi_outstanding_limiter #(
        .AW_WIDTH           (AW_WIDTH),
        .W_WIDTH            (W_WIDTH),
        .B_WIDTH            (B_WIDTH),
        .AR_WIDTH           (AR_WIDTH),
        .R_WIDTH            (R_WIDTH),
        .R_LAST_POS         (0),
        .MAX_WR_OUTSTANDING (4),
        .MAX_RD_OUTSTANDING (4)
    ) dut (
        .clk(clk), .rst(rst),
        .slave_aw_valid(slave_aw_valid), .slave_aw_info(slave_aw_info), .slave_aw_ready(slave_aw_ready),
        .slave_w_valid(slave_w_valid), .slave_w_info(slave_w_info), .slave_w_ready(slave_w_ready),
        .slave_ar_valid(slave_ar_valid), .slave_ar_info(slave_ar_info), .slave_ar_ready(slave_ar_ready),
        .slave_b_valid(slave_b_valid), .slave_b_info(slave_b_info), .slave_b_ready(slave_b_ready),
        .slave_r_valid(slave_r_valid), .slave_r_info(slave_r_info), .slave_r_ready(slave_r_ready),
        .master_aw_valid(master_aw_valid), .master_aw_info(master_aw_info), .master_aw_ready(master_aw_ready),
        .master_w_valid(master_w_valid), .master_w_info(master_w_info), .master_w_ready(master_w_ready),
        .master_ar_valid(master_ar_valid), .master_ar_info(master_ar_info), .master_ar_ready(master_ar_ready),
        .master_b_valid(master_b_valid), .master_b_info(master_b_info), .master_b_ready(master_b_ready),
        .master_r_valid(master_r_valid), .master_r_info(master_r_info), .master_r_ready(master_r_ready),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
        .err_underflow(err_underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (slave_aw_valid && slave_aw_ready) aw_accepts <= aw_accepts + 1;
    end

    function automatic logic [63:0] actual(input sel_e s);
        case (s)
            S_WR:     return 64'(wr_outstanding);
            S_RD:     return 64'(rd_outstanding);
            S_ERR:    return 64'(err_underflow);
            S_AW_RDY: return 64'(slave_aw_ready);
            S_AW_VLD: return 64'(master_aw_valid);
            S_AR_RDY: return 64'(slave_ar_ready);
            S_AR_VLD: return 64'(master_ar_valid);
            S_W_VLD:  return 64'(master_w_valid);
            S_B_VLD:  return 64'(slave_b_valid);
            S_R_VLD:  return 64'(slave_r_valid);
            S_AW_ACC: return 64'(aw_accepts);
            S_W_INFO: return master_w_info;
            default:  return '1;
        endcase
    endfunction

    // monitor: expectations queued during a cycle are checked at that cycle's negedge
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            logic [63:0] a;
            e = sb.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.exp) begin
                errors++;
                $display("FAIL %s actual %0h expected %0h at %0t", e.name, a, e.exp, $time);
            end
        end
    end

    task automatic expect_val(input string name, input sel_e sel, input logic [63:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        slave_aw_valid = 1'b0; slave_aw_info = 32'hA000_0000;
        slave_w_valid = 1'b0;  slave_w_info = '0;
        slave_ar_valid = 1'b0; slave_ar_info = 32'hB000_0000;
        slave_b_ready = 1'b1;  slave_r_ready = 1'b1;
        master_aw_ready = 1'b1; master_w_ready = 1'b1; master_ar_ready = 1'b1;
        master_b_valid = 1'b0; master_b_info = 8'h00;
        master_r_valid = 1'b0; master_r_info = '0;
        clr_err = 1'b0;

        step();
        step();
        expect_val("rst_wr", S_WR, 0);
        expect_val("rst_rd", S_RD, 0);
        expect_val("rst_err", S_ERR, 0);
        expect_val("rst_aw_rdy", S_AW_RDY, 0);

        // six back-to-back AWs, only four accepted
        step();
        rst = 1'b0;
        slave_aw_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_val($sformatf("burst_wr%0d", i), S_WR, (i < 4) ? i : 4);
            expect_val($sformatf("burst_rdy%0d", i), S_AW_RDY, (i < 4) ? 1 : 0);
            expect_val($sformatf("burst_mvld%0d", i), S_AW_VLD, (i < 4) ? 1 : 0);
            step();
        end
        expect_val("burst_accepts", S_AW_ACC, 4);

        // one B at full: slot usable only the following cycle
        master_b_valid = 1'b1;
        expect_val("bfull_wr", S_WR, 4);
        expect_val("bfull_rdy", S_AW_RDY, 0);
        expect_val("bfull_bpass", S_B_VLD, 1);
        step();
        master_b_valid = 1'b0;
        expect_val("bafter_wr", S_WR, 3);
        expect_val("bafter_rdy", S_AW_RDY, 1);
        expect_val("bafter_acc", S_AW_ACC, 4);
        step();
        slave_aw_valid = 1'b0;
        expect_val("aw5_wr", S_WR, 4);
        expect_val("aw5_acc", S_AW_ACC, 5);

        // drain to 2, then simultaneous AW and B
        master_b_valid = 1'b1;
        step();
        step();
        slave_aw_valid = 1'b1;
        expect_val("sim_pre_wr", S_WR, 2);
        step();
        slave_aw_valid = 1'b0;
        master_b_valid = 1'b0;
        expect_val("sim_wr", S_WR, 2);
        expect_val("sim_err", S_ERR, 0);

        // one AR then an 8-beat R burst with last on beat 8
        slave_ar_valid = 1'b1;
        expect_val("ar_rdy", S_AR_RDY, 1);
        step();
        slave_ar_valid = 1'b0;
        master_r_valid = 1'b1;
        for (int b = 1; b <= 8; b++) begin
            master_r_info = (b == 8) ? 64'h1 : 64'hF0;
            expect_val($sformatf("rbeat%0d_rd", b), S_RD, 1);
            expect_val($sformatf("rbeat%0d_pass", b), S_R_VLD, 1);
            step();
        end
        master_r_valid = 1'b0;
        master_r_info = '0;
        expect_val("rdone_rd", S_RD, 0);

        // drain writes to 0, then underflow and clear cases
        master_b_valid = 1'b1;
        step();
        step();
        expect_val("uf_pre_wr", S_WR, 0);
        expect_val("uf_pre_err", S_ERR, 0);
        step();
        master_b_valid = 1'b0;
        expect_val("uf_wr", S_WR, 0);
        expect_val("uf_err", S_ERR, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        expect_val("clr_err", S_ERR, 0);
        clr_err = 1'b1;
        master_b_valid = 1'b1;
        step();
        clr_err = 1'b0;
        master_b_valid = 1'b0;
        expect_val("clr_vs_set_err", S_ERR, 1);

        // build wr=3 rd=2 then reset with traffic on the pass-through channels
        slave_aw_valid = 1'b1;
        slave_ar_valid = 1'b1;
        step();
        step();
        slave_ar_valid = 1'b0;
        step();
        expect_val("prerst_wr", S_WR, 3);
        expect_val("prerst_rd", S_RD, 2);
        slave_ar_valid = 1'b1;
        rst = 1'b1;
        slave_w_valid = 1'b1;
        slave_w_info = 64'h1234_5678_9ABC_DEF0;
        master_b_valid = 1'b1;
        master_r_valid = 1'b1;
        expect_val("inrst_aw_vld", S_AW_VLD, 0);
        expect_val("inrst_aw_rdy", S_AW_RDY, 0);
        expect_val("inrst_ar_vld", S_AR_VLD, 0);
        expect_val("inrst_ar_rdy", S_AR_RDY, 0);
        expect_val("inrst_w_vld", S_W_VLD, 1);
        expect_val("inrst_w_info", S_W_INFO, 64'h1234_5678_9ABC_DEF0);
        expect_val("inrst_b_vld", S_B_VLD, 1);
        expect_val("inrst_r_vld", S_R_VLD, 1);
        step();
        rst = 1'b0;
        slave_aw_valid = 1'b0;
        slave_ar_valid = 1'b0;
        slave_w_valid = 1'b0;
        master_b_valid = 1'b0;
        master_r_valid = 1'b0;
        expect_val("postrst_wr", S_WR, 0);
        expect_val("postrst_rd", S_RD, 0);
        expect_val("postrst_err", S_ERR, 0);

        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
